// File: rtl/fixed_requantize_pkg.sv
// Shared types and constants for the fixed-point requantizer: rounding modes,
// two's-complement saturation bounds and the default saturation counter width.
package fixed_requantize_pkg;

  typedef enum logic [0:0] {
    RND_HALF_UP = 1'b0,
    RND_TRUNC   = 1'b1
  } round_mode_e;

  localparam int DEFAULT_SAT_COUNT_WIDTH = 16;

  function automatic longint sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/fixed_round_sat_lane.sv
// One lane of requantization: the rounding path feeds the S1 register, and the clamp
// path takes the S1 value back. Optional ReLU via FIXED_REQUANTIZE_RELU_EN.
module fixed_round_sat_lane
  import fixed_requantize_pkg::*;
#(
  parameter int          IN_WIDTH   = 40,
  parameter int          SHIFT      = 4,
  parameter int          OUT_WIDTH  = 8,
  parameter round_mode_e ROUND_MODE = RND_HALF_UP
) (
  input  logic signed [IN_WIDTH-1:0]  x_i,
  output logic signed [IN_WIDTH:0]    rnd_o,
  input  logic signed [IN_WIDTH:0]    rnd_i,
  output logic signed [OUT_WIDTH-1:0] y_o,
  output logic                        sat_o
);

  localparam logic signed [IN_WIDTH:0]    MAX_C     = (IN_WIDTH+1)'(sat_max(OUT_WIDTH));
  localparam logic signed [IN_WIDTH:0]    MIN_C     = (IN_WIDTH+1)'(sat_min(OUT_WIDTH));
  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX_C = OUT_WIDTH'(sat_max(OUT_WIDTH));
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN_C = OUT_WIDTH'(sat_min(OUT_WIDTH));

  logic signed [IN_WIDTH:0] ext_s;

  // One guard bit keeps the rounding bias from overflowing.
  assign ext_s = {x_i[IN_WIDTH-1], x_i};

  generate
    if (SHIFT == 0) begin : g_pass
      assign rnd_o = ext_s;
    end else begin : g_shift
      localparam logic signed [IN_WIDTH:0] HALF_C = (IN_WIDTH+1)'(64'sd1 <<< (SHIFT - 1));
      logic signed [IN_WIDTH:0] bias_s;
      assign bias_s = (ROUND_MODE == RND_HALF_UP) ? (ext_s + HALF_C) : ext_s;
      assign rnd_o  = bias_s >>> SHIFT;
    end
  endgenerate

  // Clamp to the output range; ReLU zeroing is applied afterwards and never flags.
  always_comb begin
    sat_o = 1'b0;
    y_o   = rnd_i[OUT_WIDTH-1:0];
    if (rnd_i > MAX_C) begin
      y_o   = OUT_MAX_C;
      sat_o = 1'b1;
    end else if (rnd_i < MIN_C) begin
      y_o   = OUT_MIN_C;
      sat_o = 1'b1;
    end else begin
      y_o   = rnd_i[OUT_WIDTH-1:0];
    end
`ifdef FIXED_REQUANTIZE_RELU_EN
    if (y_o[OUT_WIDTH-1]) begin
      y_o = '0;
    end else begin
      y_o = y_o;
    end
`endif
  end

endmodule

// File: rtl/fixed_requantize.sv
// Two-stage requantizer (S1 round, S2 saturate) with valid/ready handshakes and a
// sticky saturation beat counter. Build option: FIXED_REQUANTIZE_RELU_EN.
module fixed_requantize
  import fixed_requantize_pkg::*;
#(
  parameter int IN_WIDTH        = 40,
  parameter int IN_FRAC_WIDTH   = 8,
  parameter int IN_SIZE         = 2,
  parameter int OUT_WIDTH       = 8,
  parameter int OUT_FRAC_WIDTH  = 4,
  parameter int SAT_COUNT_WIDTH = DEFAULT_SAT_COUNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [IN_WIDTH-1:0]  data_in [IN_SIZE],
  input  logic                        data_in_valid,
  output logic                        data_in_ready,
  output logic signed [OUT_WIDTH-1:0] data_out [IN_SIZE],
  output logic                        data_out_valid,
  input  logic                        data_out_ready,
  output logic [SAT_COUNT_WIDTH-1:0]  sat_count
);

  localparam int SH = IN_FRAC_WIDTH - OUT_FRAC_WIDTH;

  generate
    if ((IN_FRAC_WIDTH < OUT_FRAC_WIDTH) || (IN_WIDTH <= OUT_WIDTH)) begin : g_bad_params
      $error("fixed_requantize: need IN_FRAC_WIDTH >= OUT_FRAC_WIDTH and IN_WIDTH > OUT_WIDTH");
    end
  endgenerate

  logic                        s1_valid_q, s1_valid_d;
  logic signed [IN_WIDTH:0]    s1_data_q [IN_SIZE];
  logic signed [IN_WIDTH:0]    s1_data_d [IN_SIZE];
  logic                        s2_valid_q, s2_valid_d;
  logic signed [OUT_WIDTH-1:0] s2_data_q [IN_SIZE];
  logic signed [OUT_WIDTH-1:0] s2_data_d [IN_SIZE];
  logic                        s2_sat_q, s2_sat_d;
  logic [SAT_COUNT_WIDTH-1:0]  sat_count_q, sat_count_d;

  logic signed [IN_WIDTH:0]    rnd_s [IN_SIZE];
  logic signed [OUT_WIDTH-1:0] y_s   [IN_SIZE];
  logic [IN_SIZE-1:0]          sat_s;
  logic                        s2_adv_s, s1_adv_s, in_fire_s;

  for (genvar i = 0; i < IN_SIZE; i++) begin : g_lane
    fixed_round_sat_lane #(
      .IN_WIDTH  (IN_WIDTH),
      .SHIFT     (SH),
      .OUT_WIDTH (OUT_WIDTH),
      .ROUND_MODE(RND_HALF_UP)
    ) u_lane (
      .x_i  (data_in[i]),
      .rnd_o(rnd_s[i]),
      .rnd_i(s1_data_q[i]),
      .y_o  (y_s[i]),
      .sat_o(sat_s[i])
    );
  end

  assign s2_adv_s       = s2_valid_q & data_out_ready;
  assign s1_adv_s       = s1_valid_q & (~s2_valid_q | s2_adv_s);
  assign data_in_ready  = ~s1_valid_q | s2_adv_s;
  assign in_fire_s      = data_in_valid & data_in_ready;
  assign data_out       = s2_data_q;
  assign data_out_valid = s2_valid_q;
  assign sat_count      = sat_count_q;

  // Next-state for both stages and the saturation counter.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s2_valid_d  = s2_valid_q;
    s2_data_d   = s2_data_q;
    s2_sat_d    = s2_sat_q;
    sat_count_d = sat_count_q;

    if (in_fire_s) begin
      s1_valid_d = 1'b1;
      s1_data_d  = rnd_s;
    end else if (s1_adv_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (s1_adv_s) begin
      s2_valid_d = 1'b1;
      s2_data_d  = y_s;
      s2_sat_d   = |sat_s;
    end else if (s2_adv_s) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end

    // Counter sticks at all-ones instead of wrapping.
    if (s2_adv_s && s2_sat_q && (sat_count_q != {SAT_COUNT_WIDTH{1'b1}})) begin
      sat_count_d = sat_count_q + SAT_COUNT_WIDTH'(1);
    end else begin
      sat_count_d = sat_count_q;
    end
  end

  // Pipeline and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '{default: '0};
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '{default: '0};
      s2_sat_q    <= 1'b0;
      sat_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_sat_q    <= s2_sat_d;
      sat_count_q <= sat_count_d;
    end
  end

endmodule

// File: tb/tb_fixed_requantize.sv
// Scoreboard bench for fixed_requantize (IN_FRAC 8, OUT_FRAC 4, OUT_WIDTH 8, 4-bit counter).
module tb_fixed_requantize;

  localparam int IW  = 40;
  localparam int IS  = 2;
  localparam int OW  = 8;
  localparam int SCW = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [IW-1:0] din [IS];
  logic                 din_valid, din_ready;
  logic signed [OW-1:0] dout [IS];
  logic                 dout_valid, dout_ready;
  logic [SCW-1:0]       sat_count;

  always #5 clk = ~clk;

  fixed_requantize #(
    .IN_WIDTH(IW), .IN_FRAC_WIDTH(8), .IN_SIZE(IS),
    .OUT_WIDTH(OW), .OUT_FRAC_WIDTH(4), .SAT_COUNT_WIDTH(SCW)
  ) dut (
    .clk(clk), .rst(rst),
    .data_in(din), .data_in_valid(din_valid), .data_in_ready(din_ready),
    .data_out(dout), .data_out_valid(dout_valid), .data_out_ready(dout_ready),
    .sat_count(sat_count)
  );

  typedef struct packed {
    logic [15:0] lanes;
    logic        sat;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          accepted = 0;
  int          model_cnt = 0;
  logic        stalled_prev = 1'b0;
  logic [15:0] prev_out = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: floor((x + 8) / 16), clamp to int8, optional ReLU.
  function automatic void model(input longint x, output logic [7:0] y, output logic s);
    longint n, q;
    n = x + 64'sd8;
    q = n / 64'sd16;
    if ((n % 64'sd16 != 0) && (n < 0)) q = q - 64'sd1;
    s = 1'b0;
    if (q > 64'sd127) begin
      q = 64'sd127; s = 1'b1;
    end else if (q < -64'sd128) begin
      q = -64'sd128; s = 1'b1;
    end
`ifdef FIXED_REQUANTIZE_RELU_EN
    if (q < 0) q = 0;
`endif
    y = q[7:0];
  endfunction

  task automatic drive(input longint a, input longint b);
    din[0]    = a[IW-1:0];
    din[1]    = b[IW-1:0];
    din_valid = 1'b1;
  endtask

  // One clock: check outputs, update scoreboard on both handshakes, advance to next negedge.
  task automatic step();
    exp_t        e;
    logic [7:0]  y0, y1;
    logic        s0, s1;
    #1;
    chk("sat_count", 64'(sat_count), 64'(model_cnt));
    if (!rst) begin
      if (stalled_prev) begin
        chk("hold_valid", 64'(dout_valid), 64'd1);
        chk("hold_data", 64'({dout[1], dout[0]}), 64'(prev_out));
      end
      if (dout_valid && dout_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 64'(dout_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("data_out", 64'({dout[1], dout[0]}), 64'(e.lanes));
          if (e.sat && model_cnt != 15) model_cnt++;
        end
      end
      if (din_valid && din_ready) begin
        model(longint'(din[0]), y0, s0);
        model(longint'(din[1]), y1, s1);
        e.lanes = {y1, y0};
        e.sat   = s0 | s1;
        sb.push_back(e);
        accepted++;
      end
      stalled_prev = dout_valid && !dout_ready;
      prev_out     = {dout[1], dout[0]};
    end else begin
      sb.delete();
      model_cnt    = 0;
      stalled_prev = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic send(input longint a, input longint b);
    int acc0, t;
    acc0 = accepted;
    t    = 0;
    drive(a, b);
    while (accepted == acc0 && t < 20) begin
      step();
      t++;
    end
    if (accepted == acc0) chk("accept_timeout", 64'(din_ready), 64'd1);
    din_valid = 1'b0;
  endtask

  task automatic drain();
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() > 0; i++) step();
    step();
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  longint bnd_a[6] = '{64'sd8, 64'sd7, 64'sd2032, -64'sd2048, -64'sd2057, -64'sd549755813888};
  longint bnd_b[6] = '{-64'sd8, -64'sd9, 64'sd2040, -64'sd2056, 64'sd549755813887, 64'sd0};

  initial begin
    rst        = 1'b1;
    din_valid  = 1'b0;
    din[0]     = '0;
    din[1]     = '0;
    dout_ready = 1'b1;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    chk("rst_out_valid", 64'(dout_valid), 64'd0);
    chk("rst_data_out", 64'({dout[1], dout[0]}), 64'd0);
    chk("rst_in_ready", 64'(din_ready), 64'd1);

    // Basic rounding and 2-cycle latency.
    drive(64'sd296, -64'sd296);
    step();
    din_valid = 1'b0;
    chk("lat_cycle1", 64'(dout_valid), 64'd0);
    step();
    chk("lat_cycle2", 64'(dout_valid), 64'd1);
    step();
    chk("sat_after_296", 64'(sat_count), 64'd0);

    // Saturating beat.
    send(64'sd65536, -64'sd65536);
    drain();
    chk("sat_after_big", 64'(sat_count), 64'd1);

    // Rounding ties and clamp edges, streamed.
    for (int i = 0; i < 6; i++) send(bnd_a[i], bnd_b[i]);
    drain();

    // Output stalled for 5 cycles with input valid held.
    begin
      int acc0;
      acc0       = accepted;
      dout_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
        drive(64'sd100 + 64'(accepted) * 64'sd37, -64'sd300 - 64'(accepted) * 64'sd53);
        step();
      end
      chk("stall_accepts", 64'(accepted - acc0), 64'd2);
      chk("stall_in_ready", 64'(din_ready), 64'd0);
      drain();
    end

    // Random traffic with random backpressure.
    for (int i = 0; i < 60; i++) begin
      longint a, b;
      a = longint'($urandom_range(0, 6000)) - 64'sd3000;
      b = ($urandom_range(0, 3) == 0) ? (longint'($urandom_range(0, 200000)) - 64'sd100000)
                                      : (longint'($urandom_range(0, 4200)) - 64'sd2100);
      drive(a, b);
      din_valid  = ($urandom_range(0, 3) != 0);
      dout_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    drain();

    // Reset with both stages full discards in-flight beats.
    dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(64'sd65536, 64'sd500 + 64'(i));
      step();
    end
    chk("full_in_ready", 64'(din_ready), 64'd0);
    din_valid = 1'b0;
    rst       = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out_valid", 64'(dout_valid), 64'd0);
    chk("midrst_sat_count", 64'(sat_count), 64'd0);
    chk("midrst_in_ready", 64'(din_ready), 64'd1);
    dout_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("midrst_no_old", 64'(dout_valid), 64'd0);

    // Counter saturates at all-ones.
    for (int i = 0; i < 18; i++) send(64'sd65536, 64'sd65536);
    drain();
    chk("sat_count_hold", 64'(sat_count), 64'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
